queen_backtrack_controller: RTL and testbench

- Control FSM for the N-queens solver. It sits directly upstream of the stack datapath and drives its push, pop and bus_in.
- Generates candidate (row, col) placements and checks safety against internal column and diagonal occupancy masks.
- Pushes each safe placement, and pops to backtrack on a dead end, using the stack's zero and msb flags.
- Reports the solved board, or no-solution, to the top level.

---
 rtl/queen_pkg.sv | 40 ++++
 rtl/queen_safety_check.sv | 41 ++++
 rtl/queen_backtrack_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_queen_backtrack_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/queen_pkg.sv
// ============================================================================
// queen_pkg: shared FSM state type and coordinate/diagonal helpers for the
// N-queens backtracking controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package queen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        PUSH = 2'd2,
        POP  = 2'd3
    } queen_state_t;

    // Stack word layout is {row, col} with row in the upper COORD_W bits.
    function automatic int coord_pack(input int row, input int col, input int coord_w);
        return (row << coord_w) | col;
    endfunction

    function automatic int coord_row(input int word, input int coord_w);
        return word >> coord_w;
    endfunction

    function automatic int coord_col(input int word, input int coord_w);
        return word & ((1 << coord_w) - 1);
    endfunction

    function automatic int diag_a_idx(input int row, input int col);
        return row + col;
    endfunction

    function automatic int diag_b_idx(input int row, input int col, input int n);
        return row - col + n - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/queen_safety_check.sv
// ============================================================================
// queen_safety_check: combinational test of one candidate (row, col) against
// the column and both diagonal occupancy masks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module queen_safety_check
    import queen_pkg::*;
#(
    parameter  int N       = 8,
    localparam int COORD_W = $clog2(N)
) (
    input  logic [N-1:0]     i_col_used,
    input  logic [2*N-2:0]   i_diag_a_used,
    input  logic [2*N-2:0]   i_diag_b_used,
    input  logic [COORD_W-1:0] i_row,
    input  logic [COORD_W:0] i_col,
    output logic             o_safe
);

    int w_ia;
    int w_ib;

    // Loops compare against each index so an out-of-range col never indexes a mask.
    always_comb begin
        w_ia   = diag_a_idx(int'(i_row), int'(i_col));
        w_ib   = diag_b_idx(int'(i_row), int'(i_col), N);
        o_safe = (int'(i_col) < N);
        for (int i = 0; i < N; i++) begin
            if (i_col_used[i] && (i == int'(i_col))) o_safe = 1'b0;
        end
        for (int i = 0; i < 2*N-1; i++) begin
            if (i_diag_a_used[i] && (i == w_ia)) o_safe = 1'b0;
            if (i_diag_b_used[i] && (i == w_ib)) o_safe = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/queen_backtrack_controller.sv
// ============================================================================
// queen_backtrack_controller: N-queens search FSM driving an external stack.
// Optional macro QUEEN_ALL_SOLUTIONS_EN enumerates every solution.
// Revision: 1.0
// ============================================================================
`default_nettype none

module queen_backtrack_controller
    import queen_pkg::*;
#(
    parameter  int N       = 8,
    localparam int COORD_W = $clog2(N),
    localparam int SIZE    = 2*COORD_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stack_zero,
    input  logic                   stack_full,
    input  logic [SIZE-1:0]        stack_data_in,
    output logic                   push,
    output logic                   pop,
    output logic [SIZE-1:0]        stack_data_out,
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic [N*COORD_W-1:0]   queen_cols
`ifdef QUEEN_ALL_SOLUTIONS_EN
    ,
    output logic [7:0]             solution_count,
    output logic                   solution_valid
`endif
);

    localparam logic [COORD_W:0]   c_col_one = (COORD_W+1)'(1);
    localparam logic [COORD_W-1:0] c_row_one = COORD_W'(1);

    queen_state_t           r_state;
    logic [COORD_W-1:0]     r_row;
    logic [COORD_W:0]       r_col;
    logic [N-1:0]           r_col_used;
    logic [2*N-2:0]         r_diag_a;
    logic [2*N-2:0]         r_diag_b;
    logic                   r_push;
    logic                   r_pop;
    logic [SIZE-1:0]        r_data_out;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_found;
    logic [N*COORD_W-1:0]   r_queen_cols;
`ifdef QUEEN_ALL_SOLUTIONS_EN
    logic [7:0]             r_solution_count;
    logic                   r_solution_valid;
`endif

    logic                   w_safe;
    logic                   w_col_end;
    logic                   w_last_row;
    logic [COORD_W-1:0]     w_pop_row;
    logic [COORD_W-1:0]     w_pop_col;
    logic [N-1:0]           w_set_col;
    logic [N-1:0]           w_clr_col;
    logic [2*N-2:0]         w_set_da;
    logic [2*N-2:0]         w_set_db;
    logic [2*N-2:0]         w_clr_da;
    logic [2*N-2:0]         w_clr_db;

    queen_safety_check #(.N(N)) u_safety (
        .i_col_used    (r_col_used),
        .i_diag_a_used (r_diag_a),
        .i_diag_b_used (r_diag_b),
        .i_row         (r_row),
        .i_col         (r_col),
        .o_safe        (w_safe)
    );

    assign w_col_end  = (r_col == (COORD_W+1)'(N));
    assign w_last_row = (r_row == COORD_W'(N-1));
    assign w_pop_row  = COORD_W'(coord_row(int'(stack_data_in), COORD_W));
    assign w_pop_col  = COORD_W'(coord_col(int'(stack_data_in), COORD_W));

    // One-hot mask bits for the placement being pushed and the one being popped.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_set_col[i] = (i == int'(r_col));
            w_clr_col[i] = (i == int'(w_pop_col));
        end
        for (int i = 0; i < 2*N-1; i++) begin
            w_set_da[i] = (i == diag_a_idx(int'(r_row), int'(r_col)));
            w_set_db[i] = (i == diag_b_idx(int'(r_row), int'(r_col), N));
            w_clr_da[i] = (i == diag_a_idx(int'(w_pop_row), int'(w_pop_col)));
            w_clr_db[i] = (i == diag_b_idx(int'(w_pop_row), int'(w_pop_col), N));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= IDLE;
            r_row            <= '0;
            r_col            <= '0;
            r_col_used       <= '0;
            r_diag_a         <= '0;
            r_diag_b         <= '0;
            r_push           <= 1'b0;
            r_pop            <= 1'b0;
            r_data_out       <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_found          <= 1'b0;
            r_queen_cols     <= '0;
`ifdef QUEEN_ALL_SOLUTIONS_EN
            r_solution_count <= '0;
            r_solution_valid <= 1'b0;
`endif
        end else begin
            r_push <= 1'b0;
            r_pop  <= 1'b0;
            r_done <= 1'b0;
`ifdef QUEEN_ALL_SOLUTIONS_EN
            r_solution_valid <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_col_used   <= '0;
                        r_diag_a     <= '0;
                        r_diag_b     <= '0;
                        r_queen_cols <= '0;
                        r_found      <= 1'b0;
                        r_row        <= '0;
                        r_col        <= '0;
                        r_busy       <= 1'b1;
`ifdef QUEEN_ALL_SOLUTIONS_EN
                        r_solution_count <= '0;
`endif
                        r_state      <= TRY;
                    end
                end
                TRY: begin
                    if (w_col_end) begin
                        if (stack_zero) begin
`ifdef QUEEN_ALL_SOLUTIONS_EN
                            r_found <= (r_solution_count != 8'd0);
`else
                            r_found <= 1'b0;
`endif
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_pop   <= 1'b1;
                            r_state <= POP;
                        end
                    end else if (w_safe) begin
                        r_push     <= 1'b1;
                        r_data_out <= SIZE'(coord_pack(int'(r_row), int'(r_col[COORD_W-1:0]), COORD_W));
`ifdef QUEEN_ALL_SOLUTIONS_EN
                        r_solution_valid <= w_last_row;
`endif
                        r_state    <= PUSH;
                    end else begin
                        r_col <= r_col + c_col_one;
                    end
                end
                PUSH: begin
                    r_col_used <= r_col_used | w_set_col;
                    r_diag_a   <= r_diag_a | w_set_da;
                    r_diag_b   <= r_diag_b | w_set_db;
                    for (int r = 0; r < N; r++) begin
                        if (r == int'(r_row)) r_queen_cols[r*COORD_W +: COORD_W] <= r_col[COORD_W-1:0];
                    end
                    if (w_last_row) begin
`ifdef QUEEN_ALL_SOLUTIONS_EN
                        // Pop the final queen straight back and keep enumerating.
                        if (r_solution_count != 8'hFF) r_solution_count <= r_solution_count + 8'd1;
                        r_pop   <= 1'b1;
                        r_state <= POP;
`else
                        r_found <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
`endif
                    end else begin
                        r_row   <= r_row + c_row_one;
                        r_col   <= '0;
                        r_state <= TRY;
                    end
                end
                POP: begin
                    r_col_used <= r_col_used & ~w_clr_col;
                    r_diag_a   <= r_diag_a & ~w_clr_da;
                    r_diag_b   <= r_diag_b & ~w_clr_db;
                    r_row      <= w_pop_row;
                    r_col      <= {1'b0, w_pop_col} + c_col_one;
                    r_state    <= TRY;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign push           = r_push;
    assign pop            = r_pop;
    assign stack_data_out = r_data_out;
    assign busy           = r_busy;
    assign done           = r_done;
    assign found          = r_found;
    assign queen_cols     = r_queen_cols;
`ifdef QUEEN_ALL_SOLUTIONS_EN
    assign solution_count = r_solution_count;
    assign solution_valid = r_solution_valid;
`endif

    a_push_pop_excl: assert property (@(posedge clk) disable iff (reset) !(push && pop));
    a_no_push_full:  assert property (@(posedge clk) disable iff (reset) !(push && stack_full));
    a_no_pop_empty:  assert property (@(posedge clk) disable iff (reset) !(pop && stack_zero));

endmodule

`default_nettype wire

// File: tb/tb_queen_backtrack_controller.sv
// ============================================================================
// tb_queen_backtrack_controller: table-driven check of N=8 and N=4 controllers,
// each paired with a behavioural stack model.
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_queen_backtrack_controller;

    localparam int N8 = 8, W8 = 3, S8 = 6;
    localparam int N4 = 4, W4 = 2, S4 = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start8 = 1'b0;
    logic start4 = 1'b0;
    always #5 clk = ~clk;

    logic push8, pop8, busy8, done8, found8, zero8, full8;
    logic [S8-1:0] dout8, din8;
    logic [N8*W8-1:0] cols8;
    logic push4, pop4, busy4, done4, found4, zero4, full4;
    logic [S4-1:0] dout4, din4;
    logic [N4*W4-1:0] cols4;
`ifdef QUEEN_ALL_SOLUTIONS_EN
    logic [7:0] cnt8, cnt4;
    logic sv8, sv4;
`endif

    queen_backtrack_controller #(.N(N8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8),
        .stack_zero(zero8), .stack_full(full8), .stack_data_in(din8),
        .push(push8), .pop(pop8), .stack_data_out(dout8),
        .busy(busy8), .done(done8), .found(found8), .queen_cols(cols8)
`ifdef QUEEN_ALL_SOLUTIONS_EN
        , .solution_count(cnt8), .solution_valid(sv8)
`endif
    );

    queen_backtrack_controller #(.N(N4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .stack_zero(zero4), .stack_full(full4), .stack_data_in(din4),
        .push(push4), .pop(pop4), .stack_data_out(dout4),
        .busy(busy4), .done(done4), .found(found4), .queen_cols(cols4)
`ifdef QUEEN_ALL_SOLUTIONS_EN
        , .solution_count(cnt4), .solution_valid(sv4)
`endif
    );

    // Stack models: combinational read of the top entry, shared reset.
    logic [S8-1:0] stk8 [N8];
    logic [S4-1:0] stk4 [N4];
    int sp8, npush8, npop8, sp4, npush4, npop4;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp8 <= 0; npush8 <= 0; npop8 <= 0;
        end else if (push8 && sp8 < N8) begin
            stk8[sp8] <= dout8; sp8 <= sp8 + 1; npush8 <= npush8 + 1;
        end else if (pop8 && sp8 > 0) begin
            sp8 <= sp8 - 1; npop8 <= npop8 + 1;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp4 <= 0; npush4 <= 0; npop4 <= 0;
        end else if (push4 && sp4 < N4) begin
            stk4[sp4] <= dout4; sp4 <= sp4 + 1; npush4 <= npush4 + 1;
        end else if (pop4 && sp4 > 0) begin
            sp4 <= sp4 - 1; npop4 <= npop4 + 1;
        end
    end

    assign zero8 = (sp8 == 0);
    assign full8 = (sp8 == N8);
    assign din8  = (sp8 > 0) ? stk8[sp8-1] : '0;
    assign zero4 = (sp4 == 0);
    assign full4 = (sp4 == N4);
    assign din4  = (sp4 > 0) ? stk4[sp4-1] : '0;

    int checks = 0;
    int errors = 0;
    int ndone8 = 0, ndone4 = 0, nsv8 = 0, nsv4 = 0;

    always @(negedge clk) begin
        if (reset) begin
            ndone8 = 0; ndone4 = 0; nsv8 = 0; nsv4 = 0;
        end else begin
            if (done8) ndone8++;
            if (done4) ndone4++;
`ifdef QUEEN_ALL_SOLUTIONS_EN
            if (sv8) nsv8++;
            if (sv4) nsv4++;
`endif
            if ((push8 && pop8) || (push4 && pop4)) begin
                errors++; $display("FAIL push_pop_excl: push and pop both high at %0t", $time);
            end
            if ((done8 && busy8) || (done4 && busy4)) begin
                errors++; $display("FAIL busy_at_done: busy still high with done at %0t", $time);
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        bit          big;
        bit          chk_cols;
        logic [23:0] cols;
        logic        found;
        int          diff;
        logic        zero;
        logic        full;
        int          sols;
    } vec_t;

    vec_t vecs[3];

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic pulse_start(input bit big);
        @(negedge clk);
        if (big) start8 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start4 = 1'b0;
    endtask

    task automatic wait_done(input bit big, input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60000 && !ok; i++) begin
            @(negedge clk);
            ok = big ? done8 : done4;
        end
        if (!ok) begin
            errors++; $display("FAIL %s_timeout: done never seen, expected within 60000 cycles", nm);
        end
    endtask

    task automatic finish_check(input int k);
        bit b = vecs[k].big;
        check({vecs[k].name, "_found"}, b ? found8 : found4, vecs[k].found);
        check({vecs[k].name, "_busy"}, b ? busy8 : busy4, 1'b0);
        if (vecs[k].chk_cols)
            check({vecs[k].name, "_cols"}, b ? cols8 : {16'd0, cols4}, vecs[k].cols);
        check({vecs[k].name, "_zero"}, b ? zero8 : zero4, vecs[k].zero);
        check({vecs[k].name, "_full"}, b ? full8 : full4, vecs[k].full);
        check({vecs[k].name, "_push_minus_pop"}, b ? (npush8 - npop8) : (npush4 - npop4), vecs[k].diff);
`ifdef QUEEN_ALL_SOLUTIONS_EN
        check({vecs[k].name, "_sol_count"}, b ? cnt8 : cnt4, vecs[k].sols);
        check({vecs[k].name, "_sol_pulses"}, b ? nsv8 : nsv4, vecs[k].sols);
`endif
    endtask

    task automatic run_vec(input int k);
        bit ok;
        do_reset();
        pulse_start(vecs[k].big);
        wait_done(vecs[k].big, vecs[k].name, ok);
        if (ok) finish_check(k);
    endtask

    initial begin
        bit ok;
        int busy_k;
`ifdef QUEEN_ALL_SOLUTIONS_EN
        vecs[0] = '{"n8_all", 1'b1, 1'b0, 24'd0, 1'b1, 0, 1'b1, 1'b0, 92};
        vecs[1] = '{"n4_all", 1'b0, 1'b0, 24'd0, 1'b1, 0, 1'b1, 1'b0, 2};
        vecs[2] = '{"n4_all_again", 1'b0, 1'b0, 24'd0, 1'b1, 0, 1'b1, 1'b0, 2};
        busy_k = 1;
`else
        vecs[0] = '{"n8_first", 1'b1, 1'b1, {3'd3,3'd1,3'd6,3'd2,3'd5,3'd7,3'd4,3'd0}, 1'b1, 8, 1'b0, 1'b1, 0};
        vecs[1] = '{"n4_first", 1'b0, 1'b1, {16'd0,2'd2,2'd0,2'd3,2'd1}, 1'b1, 4, 1'b0, 1'b1, 0};
        vecs[2] = '{"n8_again", 1'b1, 1'b1, {3'd3,3'd1,3'd6,3'd2,3'd5,3'd7,3'd4,3'd0}, 1'b1, 8, 1'b0, 1'b1, 0};
        busy_k = 0;
`endif

        repeat (2) @(negedge clk);
        check("reset_outs_n8", {push8, pop8, dout8, busy8, done8, found8, cols8}, '0);
        check("reset_outs_n4", {push4, pop4, dout4, busy4, done4, found4, cols4}, '0);

        for (int k = 0; k < 3; k++) run_vec(k);

        // Asynchronous reset mid-search, then a clean re-run.
        do_reset();
        pulse_start(1'b1);
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            ok = (npush8 >= 20);
        end
        check("mid_reach_20_pushes", ok, 1'b1);
        check("mid_busy", busy8, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid_reset_outs", {push8, pop8, dout8, busy8, done8, found8, cols8}, '0);
        @(negedge clk); reset = 1'b0;
        run_vec(0);

        // Second start while busy must be ignored.
        do_reset();
        pulse_start(vecs[busy_k].big);
        repeat (10) @(negedge clk);
        check("busy_before_restart", vecs[busy_k].big ? busy8 : busy4, 1'b1);
        if (vecs[busy_k].big) start8 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start4 = 1'b0;
        wait_done(vecs[busy_k].big, "restart", ok);
        if (ok) finish_check(busy_k);
        repeat (20) @(negedge clk);
        check("restart_done_once", vecs[busy_k].big ? ndone8 : ndone4, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
